// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one MMU port among NUM_PORTS requesters.
// Accepts one request at a time (fixed priority or round-robin), checks its
// alignment, holds the MMU access until mmu_mem_ready (or a timeout), then
// returns a one-cycle response pulse to the granted requester.
//
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   req_valid/write/signed/width/addr/wdata   packed per-port request fields
//   req_ready            one-hot accept strobe (combinational, same cycle)
//   rsp_valid            one-hot one-cycle response pulse
//   rsp_error/rsp_rdata  response status and load data (0 for stores/errors)
//   mmu_*                single MMU access interface, driven from the latched request
module mem_access_arbiter #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS-1:0]             req_signed,
  input  logic [2*NUM_PORTS-1:0]           req_width,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  req_addr,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic                             rsp_error,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  input  logic                             mmu_mem_ready,
  input  logic [DATA_WIDTH-1:0]            mmu_data_out,
  output logic                             mmu_write_enable,
  output logic                             mmu_read_enable,
  output logic                             mmu_mem_signed_read,
  output logic [1:0]                       mmu_mem_data_width,
  output logic [ADDR_WIDTH-1:0]            mmu_address,
  output logic [DATA_WIDTH-1:0]            mmu_data_in
);

  localparam int unsigned IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  // MMU width codes
  localparam logic [1:0] WIDTH_HALF = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic                    write_q, write_d;
  logic                    signed_q, signed_d;
  logic [1:0]              width_q, width_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    error_q, error_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    any_valid_c;
  logic [IDX_W-1:0]        win_c;
  logic [NUM_PORTS-1:0]    grant_oh_c;
  logic [NUM_PORTS-1:0]    ready_c;
  logic                    sel_write_c;
  logic                    sel_signed_c;
  logic [1:0]              sel_width_c;
  logic [ADDR_WIDTH-1:0]   sel_addr_c;
  logic [DATA_WIDTH-1:0]   sel_wdata_c;
  logic                    misaligned_c;

  // Winner selection; loops scan from lowest to highest priority so the last hit wins.
  always_comb begin
    int unsigned idx;
    any_valid_c = |req_valid;
    win_c       = '0;
    idx         = 0;
    if (ARB_MODE == 0) begin
      for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
        idx = k - 1;
        if (req_valid[IDX_W'(idx)]) win_c = IDX_W'(idx);
      end
    end else begin
      // k = NUM_PORTS is the last granted port itself (lowest), k = 1 the one after it (highest)
      for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
        idx = (32'(last_q) + k) % NUM_PORTS;
        if (req_valid[IDX_W'(idx)]) win_c = IDX_W'(idx);
      end
    end
  end

  // Extract the winner's request fields
  always_comb begin
    sel_write_c  = 1'b0;
    sel_signed_c = 1'b0;
    sel_width_c  = '0;
    sel_addr_c   = '0;
    sel_wdata_c  = '0;
    grant_oh_c   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (win_c == IDX_W'(i)) begin
        sel_write_c   = req_write[i];
        sel_signed_c  = req_signed[i];
        sel_width_c   = req_width[2*i +: 2];
        sel_addr_c    = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        sel_wdata_c   = req_wdata[DATA_WIDTH*i +: DATA_WIDTH];
        grant_oh_c[i] = any_valid_c;
      end
    end
  end

  // Width codes with bit 1 set (word and the unused code) need word alignment
  assign misaligned_c = (sel_width_c[1] && (sel_addr_c[1:0] != 2'b00)) ||
                        ((sel_width_c == WIDTH_HALF) && sel_addr_c[0]);

  // Next-state and latch control
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    write_d  = write_q;
    signed_d = signed_q;
    width_d  = width_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    ready_c  = '0;

    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (any_valid_c) begin
          ready_c  = grant_oh_c;
          grant_d  = win_c;
          last_d   = win_c;
          write_d  = sel_write_c;
          signed_d = sel_signed_c;
          width_d  = sel_width_c;
          addr_d   = sel_addr_c;
          wdata_d  = sel_wdata_c;
          rdata_d  = '0;
          cnt_d    = '0;
          if (misaligned_c) begin
            state_d = S_RESP;
            error_d = 1'b1;
          end else begin
            state_d = S_BUSY;
            error_d = 1'b0;
          end
        end
      end
      S_BUSY: begin
        if (mmu_mem_ready) begin
          rdata_d = write_q ? '0 : mmu_data_out;
          error_d = 1'b0;
          state_d = S_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == CNT_W'(CNT_MAX)) begin
            rdata_d = '0;
            error_d = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_PORTS - 1);
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      width_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      width_q  <= width_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
    end
  end

  // Accept strobe is forced low while reset is held
  assign req_ready = reset_n ? ready_c : '0;

  // Response pulse decoded from the registered state
  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        rsp_valid[i] = (grant_q == IDX_W'(i));
      end
    end
  end

  assign rsp_error           = (state_q == S_RESP) && error_q;
  assign rsp_rdata           = (state_q == S_RESP) ? rdata_q : '0;
  assign mmu_read_enable     = (state_q == S_BUSY) && !write_q;
  assign mmu_write_enable    = (state_q == S_BUSY) && write_q;
  assign mmu_mem_signed_read = signed_q;
  assign mmu_mem_data_width  = width_q;
  assign mmu_address         = addr_q;
  assign mmu_data_in         = wdata_q;

endmodule
